// File: rtl/usb_log_reader.sv
// Drain-side reader for the USB traffic logger's circular capture buffer.
// Parses record headers and streams committed records byte-by-byte over valid/ready.
module usb_log_reader #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] buf_wr_ptr,
    input  logic              buf_overrun,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_abort,
    output logic [ADDR_W-1:0] level,
    output logic [15:0]       rec_count,
    output logic [15:0]       drop_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_inc;
    logic              hdr_flag;
    logic              started;
    logic [6:0]        remaining;
    logic              empty;
    logic              hs;
    logic              discard;
    logic              hdr_bad;
    logic              in_progress;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rd_ptr_inc  = rd_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign empty       = (rd_ptr == buf_wr_ptr);
    assign hs          = (state == SEND) && out_valid && out_ready;
    assign discard     = buf_overrun || flush;
    assign hdr_bad     = (state == LOAD) && hdr_flag && (mem_rd_data[7:6] == 2'b11);
    assign level       = buf_wr_ptr - rd_ptr;
    assign busy        = (state != IDLE);
    // A record counts as in progress once its header byte has been accepted downstream.
    assign in_progress = busy && started;

    always_comb begin
        state_nxt   = state;
        mem_rd_en   = 1'b0;
        mem_rd_addr = rd_ptr;
        if (discard) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !empty) begin
                        mem_rd_en = 1'b1;
                        state_nxt = LOAD;
                    end
                end
                LOAD: state_nxt = hdr_bad ? IDLE : SEND;
                SEND: begin
                    if (hs) begin
                        if (out_last) begin
                            state_nxt = IDLE;
                        end else begin
                            mem_rd_en   = 1'b1;
                            mem_rd_addr = rd_ptr_inc;
                            state_nxt   = LOAD;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            hdr_flag   <= 1'b0;
            started    <= 1'b0;
            remaining  <= 7'd0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_abort  <= 1'b0;
            rec_count  <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            state     <= state_nxt;
            out_abort <= 1'b0;
            if (discard) begin
                // A coincident handshake is dropped: neither rd_ptr++ nor rec_count++ apply.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rd_ptr    <= buf_wr_ptr;
                hdr_flag  <= 1'b0;
                started   <= 1'b0;
                out_abort <= in_progress;
                if (buf_overrun) begin
                    drop_count <= sat_inc(drop_count);
                end
            end else begin
                case (state)
                    IDLE: begin
                        started <= 1'b0;
                        if (enable && !empty) begin
                            hdr_flag <= 1'b1;
                        end
                    end
                    LOAD: begin
                        hdr_flag <= 1'b0;
                        if (hdr_bad) begin
                            rd_ptr     <= buf_wr_ptr;
                            drop_count <= sat_inc(drop_count);
                        end else begin
                            out_data  <= mem_rd_data;
                            out_valid <= 1'b1;
                            if (hdr_flag) begin
                                remaining <= 7'd4 + {1'b0, mem_rd_data[5:0]};
                                out_last  <= 1'b0;
                            end else begin
                                out_last <= (remaining == 7'd0);
                            end
                        end
                    end
                    SEND: begin
                        if (hs) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            started   <= 1'b1;
                            rd_ptr    <= rd_ptr_inc;
                            remaining <= remaining - 7'd1;
                            if (out_last) begin
                                rec_count <= sat_inc(rec_count);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_log_reader.sv
// Bench for usb_log_reader: 16-byte buffer model, record-level expected byte queue,
// directed wrap/abort/invalid/flush scenarios plus randomized backpressure traffic.
module tb_usb_log_reader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic [AW-1:0] buf_wr_ptr;
    logic          buf_overrun;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          out_abort;
    logic [AW-1:0] level;
    logic [15:0]   rec_count;
    logic [15:0]   drop_count;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    mem [16];
    logic [8:0]    exp_q [$];
    logic [AW-1:0] rd_log [$];
    bit            ready_rand = 1'b0;
    int            hs_count   = 0;
    logic          prev_stall = 1'b0;
    logic [8:0]    prev_out   = 9'd0;

    always #5 clk = ~clk;

    usb_log_reader #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .flush       (flush),
        .buf_wr_ptr  (buf_wr_ptr),
        .buf_overrun (buf_overrun),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_abort   (out_abort),
        .level       (level),
        .rec_count   (rec_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous-read RAM, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_log.push_back(mem_rd_addr);
        end
    end

    // Stream sink: drives ready, checks hold-while-stalled and each accepted byte.
    always @(negedge clk) begin
        if (!rst) begin
            out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_byte", {out_last, out_data}, prev_out);
            end
            if (out_valid && out_ready) begin
                check_eq("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("stream_byte", {out_last, out_data}, exp_q.pop_front());
                end
                hs_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
        end
    end

    // Logger model: write a whole record at the commit pointer, then commit it.
    task automatic put_record(input logic [7:0] hdr, input logic [31:0] ts,
                              input logic [63:0] pl, input bit expect_out);
        logic [7:0]    b [$];
        logic [AW-1:0] a;
        b.push_back(hdr);
        for (int i = 0; i < 4; i++) b.push_back(ts[8*i +: 8]);
        for (int i = 0; i < int'(hdr[5:0]); i++) b.push_back(pl[8*(i%8) +: 8]);
        a = buf_wr_ptr;
        for (int i = 0; i < b.size(); i++) begin
            mem[a] = b[i];
            if (expect_out) exp_q.push_back({(i == b.size() - 1), b[i]});
            a = a + 1'b1;
        end
        buf_wr_ptr = a;
    endtask

    task automatic wait_rec(input logic [15:0] target);
        for (int i = 0; i < 400 && rec_count != target; i++) @(negedge clk);
        check_eq("rec_count", rec_count, target);
    endtask

    initial begin
        logic [AW-1:0] wrap_addr [5];
        logic [15:0]   rc;
        int            hs_base;
        bit            seen_valid;
        bit            seen_abort;
        bit            seen_busy;
        logic [1:0]    typ;
        logic [5:0]    len;

        wrap_addr = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; buf_overrun = 1'b0; buf_wr_ptr = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_abort", out_abort, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rec", rec_count, 0);
        check_eq("rst_drop", drop_count, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_level", level, 0);
        rst = 1'b0;

        // Single directed record at address 0, with first-byte latency.
        @(negedge clk);
        enable = 1'b1;
        put_record(8'h03, 32'h11223344, 64'h0000_0000_00CC_BBAA, 1'b1);
        @(negedge clk);
        check_eq("lat_early_valid", out_valid, 0);
        check_eq("lat_busy", busy, 1);
        @(negedge clk);
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_first_byte", out_data, 8'h03);
        wait_rec(16'd1);
        check_eq("rec1_level", level, 0);
        check_eq("rec1_drained", exp_q.size(), 0);

        // Fill to address 14, then a 5-byte record that wraps through 15, 0, 1, 2.
        put_record(8'h41, $urandom, {$urandom, $urandom}, 1'b1);
        wait_rec(16'd2);
        rd_log.delete();
        put_record(8'h80, $urandom, 64'd0, 1'b1);
        wait_rec(16'd3);
        check_eq("wrap_reads", rd_log.size(), 5);
        for (int i = 0; i < 5 && i < rd_log.size(); i++) check_eq("wrap_addr", rd_log[i], wrap_addr[i]);
        check_eq("wrap_wr_ptr", buf_wr_ptr, 3);
        check_eq("wrap_level", level, 0);

        // Randomized records under random backpressure.
        ready_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            typ = 2'($urandom_range(0, 2));
            len = 6'($urandom_range(0, 8));
            put_record({typ, len}, $urandom, {$urandom, $urandom}, 1'b1);
            wait_rec(16'(4 + r));
        end
        ready_rand = 1'b0;
        @(negedge clk);
        check_eq("rand_drained", exp_q.size(), 0);
        check_eq("rand_level", level, 0);

        // Overrun after two bytes of a 10-byte record.
        rc = rec_count;
        hs_base = hs_count;
        put_record(8'h05, $urandom, {$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 100 && hs_count - hs_base < 2; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("ovr_two_bytes", hs_count - hs_base, 2);
        @(posedge clk);
        @(negedge clk);
        buf_overrun = 1'b1;
        @(negedge clk);
        buf_overrun = 1'b0;
        check_eq("ovr_abort", out_abort, 1);
        check_eq("ovr_valid", out_valid, 0);
        check_eq("ovr_busy", busy, 0);
        check_eq("ovr_drop", drop_count, 1);
        check_eq("ovr_level", level, 0);
        check_eq("ovr_rec", rec_count, rc);
        @(negedge clk);
        check_eq("ovr_abort_once", out_abort, 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        check_eq("ovr_no_more_bytes", hs_count - hs_base, 2);

        // Invalid header: nothing presented, resync to the commit pointer.
        hs_base = hs_count;
        seen_valid = 1'b0;
        seen_abort = 1'b0;
        put_record(8'hC5, $urandom, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_valid |= out_valid;
            seen_abort |= out_abort;
        end
        check_eq("inv_no_valid", seen_valid, 0);
        check_eq("inv_no_abort", seen_abort, 0);
        check_eq("inv_drop", drop_count, 2);
        check_eq("inv_level", level, 0);
        check_eq("inv_rec", rec_count, rc);

        // Disabled reader holds in IDLE; flush discards without counting a drop.
        enable = 1'b0;
        seen_busy = 1'b0;
        put_record(8'h02, $urandom, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        check_eq("dis_busy", seen_busy, 0);
        check_eq("dis_level", level, 7);
        check_eq("dis_no_bytes", hs_count - hs_base, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_level", level, 0);
        check_eq("flush_drop", drop_count, 2);
        check_eq("flush_abort", out_abort, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("flush_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_log_reader.md
# usb_log_reader

Drain-side companion to `usb_traffic_logger`. It reads committed capture records out of the logger's circular byte buffer through a synchronous RAM read port. It parses each record header and streams the record byte-by-byte over a valid/ready interface, marking record boundaries, so the data can feed the CDC debug console TX path or a DMA engine. Runs in the ULPI clock domain alongside the logger.

## Interface
Parameters:
- `ADDR_W`, 13, log2 of the logger buffer depth in bytes; must match the logger's `BUFFER_DEPTH_LOG2`.

Ports:
- `clk`  in  1  ULPI clock, 60 MHz.
- `rst`  in  1  Synchronous, active-high reset.
- `enable`  in  1  Permits starting a new record. Sampled only in IDLE.
- `flush`  in  1  Single-cycle pulse that discards all unread data.
- `buf_wr_ptr`  in  ADDR_W  Logger commit pointer, the next byte address to be written. It advances only by whole records.
- `buf_overrun`  in  1  Single-cycle pulse: the logger overwrote unread data.
- `mem_rd_en`  out  1  RAM read strobe (combinational).
- `mem_rd_addr`  out  ADDR_W  RAM read address (combinational).
- `mem_rd_data`  in  8  RAM read data, valid 1 cycle after `mem_rd_en`.
- `out_data`  out  8  Stream byte.
- `out_valid`  out  1  Stream valid.
- `out_ready`  in  1  Stream ready.
- `out_last`  out  1  Qualifies the final byte of a record.
- `out_abort`  out  1  1-cycle pulse when a partially sent record is abandoned.
- `level`  out  ADDR_W  Unread bytes: (`buf_wr_ptr` − `rd_ptr`) mod 2^ADDR_W.
- `rec_count`  out  16  Records fully delivered. Saturates at 0xFFFF.
- `drop_count`  out  16  Resync events. Saturates at 0xFFFF.
- `busy`  out  1  High whenever the state is not IDLE.

## Operation
- Record format:
  - byte0 is the header: [7:6] type, [5:0] payload length L (0–63).
  - bytes 1–4 are the timestamp, little-endian.
  - bytes 5..4+L are the payload.
  - Total record size is 5+L bytes.
  - Type 2'b11 is reserved/invalid.
- Empty condition: `rd_ptr == buf_wr_ptr`. The logger never lets the unread count reach 2^ADDR_W, so equality always means empty.
- Because commits are whole-record, a non-empty buffer always holds at least one complete record.
- States:
  - IDLE: if `enable` and not empty, assert `mem_rd_en` with `mem_rd_addr = rd_ptr`, set `hdr_flag`, go to LOAD.
  - LOAD: register `mem_rd_data` into `out_data` and set `out_valid`.
    - If this is the header byte and type = 11: do not present it. Set `rd_ptr <= buf_wr_ptr`, increment `drop_count`, go to IDLE.
    - If this is a valid header: `remaining <= 4+L`.
    - Otherwise go to SEND. `out_last` is high when `remaining == 0`.
  - SEND: hold `out_data`, `out_valid` and `out_last` stable until `out_ready`. On handshake, `rd_ptr <= rd_ptr+1` (wraps modulo 2^ADDR_W) and `remaining <= remaining−1`.
    - If the byte was last: increment `rec_count` and go to IDLE.
    - Otherwise, in the same cycle, assert `mem_rd_en` with `mem_rd_addr = rd_ptr+1` and go to LOAD.
- Deasserting `enable` mid-record has no effect until the record completes.
- Priority, highest first: `rst` > `buf_overrun` > `flush` > normal FSM.
  - `buf_overrun`: `out_valid <= 0`, `rd_ptr <= buf_wr_ptr`, `drop_count++`, go to IDLE.
  - `flush`: same as `buf_overrun` but without the `drop_count` increment.
  - Either event pulses `out_abort` on the next cycle if a record was in progress, meaning the state was LOAD or SEND after its header had been handshaken.
  - An abort in the same cycle as a handshake: the handshake does not count and `rec_count` is unchanged.

## Timing
- Reset values: `rd_ptr` = 0, state = IDLE, and `out_valid`, `out_last`, `out_abort`, `busy`, `rec_count`, `drop_count`, `out_data` are all 0.
- First byte latency: `out_valid` rises 2 cycles after IDLE sees non-empty with `enable` high (read issued in cycle 0, LOAD in cycle 1, valid in cycle 2).
- Throughput: 1 byte per 2 cycles with `out_ready` held high. A 5+L byte record takes 2·(5+L) cycles from the IDLE start, plus 1 cycle back in IDLE before the next record.
- `level` is combinational from the current `rd_ptr` and `buf_wr_ptr`.
- `buf_wr_ptr` advancing during a record does not affect the record in progress.

## Test plan
- Single record with header 0x03, timestamp 0x11223344 and payload AA BB CC at address 0, `out_ready` = 1:
  - Expect bytes 03 44 33 22 11 AA BB CC.
  - `out_last` only on CC.
  - `rec_count` = 1, final `rd_ptr` = 8, `level` = 0.
- Wrap-around with ADDR_W = 4: a record with L = 0 starting at address 14 is read from 14, 15, 0, 1, 2. Final `rd_ptr` = 3.
- Backpressure: `out_ready` toggles randomly. Every byte must hold stable until its handshake, no byte may be lost or duplicated, and `out_last` must be aligned with the last byte.
- `buf_overrun` pulse after 2 bytes of a 10-byte record:
  - `out_valid` drops and `out_abort` pulses once.
  - `drop_count` = 1 and `rd_ptr` = `buf_wr_ptr`.
  - `rec_count` is unchanged.
- Invalid header 0xC5:
  - No byte is presented.
  - `drop_count` increments and `rd_ptr` jumps to `buf_wr_ptr`.
  - `out_abort` stays low.
- `enable` = 0 with data present: stays in IDLE and `busy` = 0. Asserting `flush` sets `level` to 0 on the next cycle and leaves `drop_count` unchanged.
